ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the primary (read/write) port of the 32K-word main RAM among three bus masters: m0 = CPU, m1 = DMA/serial loader, m2 = video fetch.
- Sits between the masters and the RAM's addr/rd/wr/indata/data port. The RAM's second read-only port is unaffected.
- Each master uses a req/ack handshake. Accesses are serialised one at a time, with rd and wr never both asserted toward the RAM.

Parameters:
- N, 16, data and address width (matches RAM word and address width).

Ports:
- clk  in  1  system clock; RAM samples on negedge, arbiter on posedge
- rst_n  in  1  asynchronous active-low reset
- mX_req  in  1  request, X in {0,1,2}
- mX_we  in  1  1 = write, 0 = read
- mX_addr  in  N  word address
- mX_wdata  in  N  write data
- mX_rdata  out  N  read data, valid while mX_ack=1
- mX_ack  out  1  one-cycle completion pulse
- ram_addr  out  N  to RAM addr
- ram_rd  out  1  to RAM rd
- ram_wr  out  1  to RAM wr
- ram_indata  out  N  to RAM indata
- ram_data  in  N  from RAM data (registered by RAM on negedge)
- busy  out  1  1 in any state other than IDLE
- gnt_id  out  2  index of current or last granted master (debug)

Behaviour:
- All outputs are registered on posedge clk.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all ack, ram_rd, ram_wr and busy = 0
  - ram_addr, ram_indata and all mX_rdata = 0
  - gnt_id=0; round-robin pointer last=2, so m0 is first in order
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No req asserted: stay in IDLE.
  - Otherwise choose the winner (see arbitration).
  - Latch winner's addr/wdata into ram_addr/ram_indata.
  - Set ram_wr = mX_we and ram_rd = !mX_we. Set gnt_id = winner, last = winner, busy=1. Go to ACCESS.
- ACCESS (exactly one cycle):
  - The RAM performs the operation on this cycle's negedge.
  - At the next posedge: clear ram_rd/ram_wr.
  - For a read, copy ram_data into the winner's mX_rdata; for a write, leave mX_rdata unchanged.
  - Set winner's mX_ack=1 and go to ACK.
- ACK (one cycle):
  - Winner's ack is high; no arbitration takes place.
  - At the next posedge: clear ack and busy, go to IDLE.
- Handshake rules for masters:
  - Hold req, we, addr and wdata stable from assertion until ack is sampled high.
  - Drop or replace the request at the same edge ack is sampled.
  - mX_rdata holds its value until that master's next read completes.
- Latency: 3 cycles per transaction (IDLE grant → ACCESS → ACK). Maximum throughput is one access per 3 cycles.
- Arbitration (base): round-robin. The search starts at last+1 mod 3 and the first requesting master wins.
  - Example: last=0 and m0, m1, m2 all requesting → m1 wins.
- A req that drops before being granted is simply ignored; it is legal but discouraged.
- Wrap-around: the pointer goes 2 → 0. Addresses pass through unchanged; the RAM uses the low 15 bits.
- Never assert ram_rd and ram_wr together; the RAM would treat that as a no-op.
- Reset mid-transaction: abort immediately and issue no ack. A write already sampled by the RAM at the negedge may have completed; the master must reissue.
- Simultaneous events: a new req arriving during ACCESS/ACK waits for IDLE. The current winner's re-request competes normally under round-robin.

Optional Feature:
- Macro: RAM_ARB_CPU_PRIO_EN.
- Defined: m0 wins in IDLE whenever m0_req=1. Round-robin applies only between m1 and m2, and the pointer updates only on m1/m2 grants. Worst-case m1/m2 wait is unbounded while m0 saturates.
- Undefined: pure three-way round-robin as above. Worst-case wait for any master is 2 transactions (6 cycles) plus its own.

Test Plan:
- Reset, then m0 writes 0x1234 to 0x0010 → ram_wr=1 for exactly one cycle with ram_addr=0x0010 and ram_indata=0x1234; m0_ack pulses 2 cycles after grant; ram_rd stays 0 throughout.
- m1 reads 0x0010 after that write → ram_rd=1 for one cycle; m1_rdata=0x1234 while m1_ack=1; m0_rdata unchanged.
- m0, m1, m2 all request reads continuously from reset → grant order 0, 1, 2, 0, 1 with acks spaced 3 cycles apart; busy goes low for one cycle between each transaction.
- With RAM_ARB_CPU_PRIO_EN, m0 requesting continuously alongside m1 and m2 → only m0 is granted. After m0 drops, m1 then m2 are granted.
- rst_n pulled low during ACCESS of an m2 read → no m2_ack; all outputs return to 0 immediately; after release, the first grant goes to m0 if it is requesting.
- Single master m2 re-requests back-to-back → granted every 3 cycles with no idle gap beyond the IDLE cycle; ram_rd and ram_wr are never 1 simultaneously (assertion checked every cycle).

Source files
------------

// File: rtl/ram_arbiter.sv
// Three-master req/ack arbiter for the main RAM read/write port (IDLE -> ACCESS -> ACK).
// Optional macro RAM_ARB_CPU_PRIO_EN gives m0 absolute priority; m1/m2 then round-robin.
module ram_arbiter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_m0_req,
    input  logic         i_m0_we,
    input  logic [N-1:0] i_m0_addr,
    input  logic [N-1:0] i_m0_wdata,
    output logic [N-1:0] o_m0_rdata,
    output logic         o_m0_ack,
    input  logic         i_m1_req,
    input  logic         i_m1_we,
    input  logic [N-1:0] i_m1_addr,
    input  logic [N-1:0] i_m1_wdata,
    output logic [N-1:0] o_m1_rdata,
    output logic         o_m1_ack,
    input  logic         i_m2_req,
    input  logic         i_m2_we,
    input  logic [N-1:0] i_m2_addr,
    input  logic [N-1:0] i_m2_wdata,
    output logic [N-1:0] o_m2_rdata,
    output logic         o_m2_ack,
    output logic [N-1:0] o_ram_addr,
    output logic         o_ram_rd,
    output logic         o_ram_wr,
    output logic [N-1:0] o_ram_indata,
    input  logic [N-1:0] i_ram_data,
    output logic         o_busy,
    output logic [1:0]   o_gnt_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_last;
    logic [1:0]   r_gnt;
    logic [N-1:0] r_ram_addr;
    logic [N-1:0] r_ram_indata;
    logic         r_ram_rd;
    logic         r_ram_wr;
    logic [2:0]   r_ack;
    logic         r_busy;
    logic [N-1:0] r_rdata [3];

    logic [2:0]   w_req;
    logic [2:0]   w_we;
    logic [N-1:0] w_addr  [3];
    logic [N-1:0] w_wdata [3];
    logic [2:0]   w_pick;
    logic         w_pick_valid;
    logic [1:0]   w_win;

    assign w_req      = {i_m2_req, i_m1_req, i_m0_req};
    assign w_we       = {i_m2_we, i_m1_we, i_m0_we};
    assign w_addr[0]  = i_m0_addr;
    assign w_addr[1]  = i_m1_addr;
    assign w_addr[2]  = i_m2_addr;
    assign w_wdata[0] = i_m0_wdata;
    assign w_wdata[1] = i_m1_wdata;
    assign w_wdata[2] = i_m2_wdata;

    // Returns {valid, index} of the first requester in the order a, b, c.
    function automatic logic [2:0] first_of(input logic [2:0] req, input logic [1:0] a,
                                            input logic [1:0] b, input logic [1:0] c);
        logic [2:0] res;
        if (req[a]) begin
            res = {1'b1, a};
        end else if (req[b]) begin
            res = {1'b1, b};
        end else if (req[c]) begin
            res = {1'b1, c};
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    // Winner selection: search begins just after the last granted master.
    function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] last);
        logic [2:0] res;
`ifdef RAM_ARB_CPU_PRIO_EN
        if (req[0]) begin
            res = {1'b1, 2'd0};
        end else if (last == 2'd1) begin
            res = first_of({req[2:1], 1'b0}, 2'd2, 2'd1, 2'd0);
        end else begin
            res = first_of({req[2:1], 1'b0}, 2'd1, 2'd2, 2'd0);
        end
`else
        case (last)
            2'd0:    res = first_of(req, 2'd1, 2'd2, 2'd0);
            2'd1:    res = first_of(req, 2'd2, 2'd0, 2'd1);
            default: res = first_of(req, 2'd0, 2'd1, 2'd2);
        endcase
`endif
        return res;
    endfunction

    assign w_pick       = pick(w_req, r_last);
    assign w_pick_valid = w_pick[2];
    assign w_win        = w_pick[1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one ACCESS cycle and one ACK cycle per granted request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: w_state_nxt = ST_ACK;
            ST_ACK:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered RAM-side strobes, grant bookkeeping, read capture and acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last       <= 2'd2;
            r_gnt        <= 2'd0;
            r_ram_addr   <= '0;
            r_ram_indata <= '0;
            r_ram_rd     <= 1'b0;
            r_ram_wr     <= 1'b0;
            r_ack        <= 3'b000;
            r_busy       <= 1'b0;
            r_rdata[0]   <= '0;
            r_rdata[1]   <= '0;
            r_rdata[2]   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_ram_addr   <= w_addr[w_win];
                        r_ram_indata <= w_wdata[w_win];
                        r_ram_wr     <= w_we[w_win];
                        r_ram_rd     <= ~w_we[w_win];
                        r_gnt        <= w_win;
                        r_busy       <= 1'b1;
`ifdef RAM_ARB_CPU_PRIO_EN
                        if (w_win != 2'd0) begin
                            r_last <= w_win;
                        end else begin
                            r_last <= r_last;
                        end
`else
                        r_last <= w_win;
`endif
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    // RAM has registered read data on the preceding negedge.
                    r_ram_rd <= 1'b0;
                    r_ram_wr <= 1'b0;
                    if (r_ram_rd) begin
                        r_rdata[r_gnt] <= i_ram_data;
                    end else begin
                        r_rdata[r_gnt] <= r_rdata[r_gnt];
                    end
                    r_ack[r_gnt] <= 1'b1;
                end
                ST_ACK: begin
                    r_ack  <= 3'b000;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_ram_rd <= 1'b0;
                    r_ram_wr <= 1'b0;
                    r_ack    <= 3'b000;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_m0_rdata   = r_rdata[0];
    assign o_m1_rdata   = r_rdata[1];
    assign o_m2_rdata   = r_rdata[2];
    assign o_m0_ack     = r_ack[0];
    assign o_m1_ack     = r_ack[1];
    assign o_m2_ack     = r_ack[2];
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_indata = r_ram_indata;
    assign o_ram_rd     = r_ram_rd;
    assign o_ram_wr     = r_ram_wr;
    assign o_busy       = r_busy;
    assign o_gnt_id     = r_gnt;

endmodule
